life_sequencer: RTL and testbench

- Control and sequencing block for the 8x8 Game-of-Life board, which is a 64-bit vector driven to the HDMI/display path.
- Loads a 64-bit seed on a start request and advances generations at a programmable tick rate.
- Supports pause and single-step.
- Halts automatically on a still life or on extinction, and reports the generation count and status flags to the display and overlay logic.

---
 rtl/life_pkg.sv | 32 +++
 rtl/life_next_gen.sv | 45 ++++
 rtl/life_sequencer.sv | 159 +++++++++++++++
 tb/tb_life_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 Game-of-Life sequencer and its next-generation
// logic: board geometry, board type, sequencer states and small helpers.
package life_pkg;

    localparam int GRID_N = 32'sd8;
    localparam int CELLS  = 32'sd64;

    typedef logic [CELLS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    // Bit position of cell (r,c) inside a board_t.
    function automatic int cell_idx(input int r, input int c);
        return (GRID_N * r) + c;
    endfunction

    // Number of live neighbours among eight neighbour bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational B3/S23 next-generation function for an 8x8 board.
// Ports:
//   board_in  - current board, cell (r,c) at bit 8*r+c
//   board_out - board after one generation
// WRAP=1 treats the edges as toroidal; WRAP=0 treats off-board cells as dead.
module life_next_gen
    import life_pkg::*;
#(
    parameter int WRAP = 1
) (
    input  board_t board_in,
    output board_t board_out
);

    // One cell per generate iteration; neighbour positions are resolved at
    // elaboration so each cell is just an 8-input popcount plus the rule.
    for (genvar gr = 0; gr < GRID_N; gr++) begin : g_row
        for (genvar gc = 0; gc < GRID_N; gc++) begin : g_col
            localparam int SELF = cell_idx(gr, gc);
            logic [7:0] nbr_s;
            logic [3:0] cnt_s;

            // Neighbour k: 0..2 row above, 3/4 same row left/right, 5..7 row below.
            for (genvar gk = 0; gk < 8; gk++) begin : g_nbr
                localparam int DR = (gk < 32'sd3) ? -32'sd1 :
                                    ((gk < 32'sd5) ? 32'sd0 : 32'sd1);
                localparam int DC = (gk < 32'sd3) ? (gk - 32'sd1) :
                                    ((gk == 32'sd3) ? -32'sd1 :
                                    ((gk == 32'sd4) ? 32'sd1 : (gk - 32'sd6)));
                localparam int NR = gr + DR;
                localparam int NC = gc + DC;
                localparam bit INSIDE = (NR >= 32'sd0) && (NR < GRID_N) &&
                                        (NC >= 32'sd0) && (NC < GRID_N);
                localparam int IDX = cell_idx((NR + GRID_N) % GRID_N,
                                              (NC + GRID_N) % GRID_N);
                assign nbr_s[gk] = ((WRAP != 32'sd0) || INSIDE) ? board_in[IDX] : 1'b0;
            end

            assign cnt_s = popcount8(nbr_s);
            assign board_out[SELF] = (cnt_s == 4'd3) ||
                                     (board_in[SELF] && (cnt_s == 4'd2));
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Game-of-Life sequencer: loads a seed on a start edge, advances generations
// every TICK_DIV cycles while running, supports pause and single-step, and
// halts on a still life or extinction.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start, pause, step   - level controls (start/step act on rising edges)
//   seed                 - initial board loaded on a start edge
//   outp                 - current board (registered)
//   gen_count            - generations since last load, saturating
//   gen_valid            - one-cycle pulse after outp takes a new generation
//   running              - high while free-running
//   stable, extinct      - sticky halt causes
module life_sequencer
    import life_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int GEN_W    = 16,
    parameter int WRAP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic [63:0]      seed,
    output logic [63:0]      outp,
    output logic [GEN_W-1:0] gen_count,
    output logic             gen_valid,
    output logic             running,
    output logic             stable,
    output logic             extinct
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'sd1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(32'd1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(32'd0);
    localparam logic [GEN_W-1:0]  GEN_ONE   = GEN_W'(32'd1);
    localparam logic [GEN_W-1:0]  GEN_ZERO  = GEN_W'(32'd0);
    localparam logic [GEN_W-1:0]  GEN_MAX   = {GEN_W{1'b1}};

    seq_state_t        state_r;
    board_t            board_r;
    logic [GEN_W-1:0]  gen_r;
    logic [TICK_W-1:0] tick_r;
    logic              start_q_r;
    logic              step_q_r;
    logic              gen_valid_r;
    logic              running_r;
    logic              stable_r;
    logic              extinct_r;

    board_t next_s;
    logic   start_edge_s;
    logic   step_edge_s;
    logic   apply_s;
    logic   next_same_s;
    logic   next_zero_s;

    life_next_gen #(.WRAP(WRAP)) u_next_gen (
        .board_in  (board_r),
        .board_out (next_s)
    );

    assign start_edge_s = start & ~start_q_r;
    assign step_edge_s  = step & ~step_q_r;
    assign next_same_s  = (next_s == board_r);
    assign next_zero_s  = (next_s == {CELLS{1'b0}});

    // A generation is due on the terminal tick in RUN (unless pause wins) or
    // on a step edge while staying paused; a start edge overrides both.
    assign apply_s = ~start_edge_s &
                     (((state_r == RUN) & ~pause & (tick_r == TICK_LAST)) |
                      ((state_r == PAUSE) & pause & step_edge_s));

    // Sequencer FSM, tick counter, board register, edge detectors and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            board_r     <= {CELLS{1'b0}};
            gen_r       <= GEN_ZERO;
            tick_r      <= TICK_ZERO;
            start_q_r   <= 1'b0;
            step_q_r    <= 1'b0;
            gen_valid_r <= 1'b0;
            running_r   <= 1'b0;
            stable_r    <= 1'b0;
            extinct_r   <= 1'b0;
        end else begin
            start_q_r   <= start;
            step_q_r    <= step;
            gen_valid_r <= 1'b0;
            if (start_edge_s) begin
                board_r   <= seed;
                gen_r     <= GEN_ZERO;
                tick_r    <= TICK_ZERO;
                stable_r  <= 1'b0;
                extinct_r <= 1'b0;
                state_r   <= pause ? PAUSE : RUN;
                running_r <= ~pause;
            end else begin
                case (state_r)
                    IDLE: state_r <= IDLE;
                    RUN: begin
                        if (pause) begin
                            // tick is held so the cadence resumes where it left off
                            state_r   <= PAUSE;
                            running_r <= 1'b0;
                        end else if (tick_r == TICK_LAST) begin
                            tick_r <= TICK_ZERO;
                        end else begin
                            tick_r <= tick_r + TICK_ONE;
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r <= PAUSE;
                        end
                    end
                    HALT: state_r <= HALT;
                    default: begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                endcase
                if (apply_s) begin
                    if (next_same_s) begin
                        // still life (including an empty board): nothing new to show
                        stable_r  <= 1'b1;
                        state_r   <= HALT;
                        running_r <= 1'b0;
                    end else begin
                        board_r     <= next_s;
                        gen_valid_r <= 1'b1;
                        if (gen_r != GEN_MAX) begin
                            gen_r <= gen_r + GEN_ONE;
                        end
                        if (next_zero_s) begin
                            extinct_r <= 1'b1;
                            state_r   <= HALT;
                            running_r <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign outp      = board_r;
    assign gen_count = gen_r;
    assign gen_valid = gen_valid_r;
    assign running   = running_r;
    assign stable    = stable_r;
    assign extinct   = extinct_r;

endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset, start, pause, step;
    logic [63:0] seed;
    logic [63:0] outp_w, outp_n;
    logic [15:0] gc_w, gc_n;
    logic        gv_w, gv_n, run_w, run_n, st_w, st_n, ex_w, ex_n;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] board;
        logic [15:0] gen;
        logic        extinct;
    } exp_t;

    exp_t q_w[$];
    exp_t q_n[$];

    // model index 0 mirrors the WRAP=1 instance, index 1 the WRAP=0 instance
    int          m_mode[2];
    logic [63:0] m_board[2];
    int          m_gen[2];
    int          m_tick[2];
    bit          m_stable[2], m_ext[2], m_gv[2];
    bit          prev_start, prev_step;

    always #5 clk = ~clk;

    life_sequencer #(.TICK_DIV(TD), .GEN_W(16), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step), .seed(seed),
        .outp(outp_w), .gen_count(gc_w), .gen_valid(gv_w), .running(run_w),
        .stable(st_w), .extinct(ex_w));

    life_sequencer #(.TICK_DIV(TD), .GEN_W(16), .WRAP(0)) dut_n (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step), .seed(seed),
        .outp(outp_n), .gen_count(gc_n), .gen_valid(gv_n), .running(run_n),
        .stable(st_n), .extinct(ex_n));

    function automatic logic [63:0] life(input logic [63:0] b, input bit wrap);
        logic [63:0] nb;
        nb = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + 8) % 8;
                                cc = (cc + 8) % 8;
                            end
                            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                                n += int'(b[rr*8+cc]);
                        end
                    end
                end
                nb[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
            end
        end
        return nb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_mode[w] = M_IDLE; m_board[w] = 64'd0; m_gen[w] = 0; m_tick[w] = 0;
            m_stable[w] = 0; m_ext[w] = 0; m_gv[w] = 0;
        end
        prev_start = 0;
        prev_step = 0;
        q_w.delete();
        q_n.delete();
    endtask

    task automatic apply_gen(input int w);
        logic [63:0] nb;
        exp_t e;
        nb = life(m_board[w], (w == 0));
        if (nb == m_board[w]) begin
            m_stable[w] = 1;
            m_mode[w] = M_HALT;
        end else begin
            m_board[w] = nb;
            if (m_gen[w] < 65535) m_gen[w]++;
            m_gv[w] = 1;
            if (nb == 64'd0) begin
                m_ext[w] = 1;
                m_mode[w] = M_HALT;
            end
            e.board = nb;
            e.gen = m_gen[w][15:0];
            e.extinct = m_ext[w];
            if (w == 0) q_w.push_back(e);
            else q_n.push_back(e);
        end
    endtask

    // Predict what the next rising edge does given the present inputs.
    task automatic model_step();
        bit se, pe;
        se = start && !prev_start;
        pe = step && !prev_step;
        for (int w = 0; w < 2; w++) begin
            m_gv[w] = 0;
            if (se) begin
                m_board[w] = seed; m_gen[w] = 0; m_tick[w] = 0;
                m_stable[w] = 0; m_ext[w] = 0;
                m_mode[w] = pause ? M_PAUSE : M_RUN;
            end else if (m_mode[w] == M_RUN) begin
                if (pause) m_mode[w] = M_PAUSE;
                else if (m_tick[w] == TD - 1) begin
                    m_tick[w] = 0;
                    apply_gen(w);
                end else m_tick[w]++;
            end else if (m_mode[w] == M_PAUSE) begin
                if (!pause) m_mode[w] = M_RUN;
                else if (pe) apply_gen(w);
            end
        end
        prev_start = start;
        prev_step = step;
    endtask

    task automatic check_status();
        chk("w_outp", outp_w, m_board[0]);
        chk("w_gen", {48'd0, gc_w}, 64'(m_gen[0]));
        chk("w_running", {63'd0, run_w}, {63'd0, (m_mode[0] == M_RUN)});
        chk("w_stable", {63'd0, st_w}, {63'd0, m_stable[0]});
        chk("w_extinct", {63'd0, ex_w}, {63'd0, m_ext[0]});
        chk("w_gen_valid", {63'd0, gv_w}, {63'd0, m_gv[0]});
        chk("n_outp", outp_n, m_board[1]);
        chk("n_gen", {48'd0, gc_n}, 64'(m_gen[1]));
        chk("n_running", {63'd0, run_n}, {63'd0, (m_mode[1] == M_RUN)});
        chk("n_stable", {63'd0, st_n}, {63'd0, m_stable[1]});
        chk("n_extinct", {63'd0, ex_n}, {63'd0, m_ext[1]});
        chk("n_gen_valid", {63'd0, gv_n}, {63'd0, m_gv[1]});
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            if (reset) model_reset();
            else model_step();
            @(posedge clk);
            #1;
            check_status();
        end
    endtask

    task automatic load(input logic [63:0] s, input logic p);
        seed = s;
        pause = p;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
    endtask

    // Scoreboard monitor: every gen_valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (gv_w) begin
                if (q_w.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL w_sb: gen_valid with no expected generation, outp=%h", outp_w);
                end else begin
                    e = q_w.pop_front();
                    chk("w_sb_board", outp_w, e.board);
                    chk("w_sb_gen", {48'd0, gc_w}, {48'd0, e.gen});
                    chk("w_sb_extinct", {63'd0, ex_w}, {63'd0, e.extinct});
                end
            end
            if (gv_n) begin
                if (q_n.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n_sb: gen_valid with no expected generation, outp=%h", outp_n);
                end else begin
                    e = q_n.pop_front();
                    chk("n_sb_board", outp_n, e.board);
                    chk("n_sb_gen", {48'd0, gc_n}, {48'd0, e.gen});
                    chk("n_sb_extinct", {63'd0, ex_n}, {63'd0, e.extinct});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0; seed = 64'd0;
        model_reset();
        cycle(3);
        reset = 1'b0;
        cycle(2);

        // blinker with start held high: exactly one load
        seed = 64'h0000_0000_0000_1C00;
        start = 1'b1;
        cycle(5);
        chk("blinker_g1_board", outp_w, 64'h0000_0000_0008_0808);
        chk("blinker_g1_gen", {48'd0, gc_w}, 64'd1);
        cycle(4);
        chk("blinker_g2_board", outp_w, 64'h0000_0000_0000_1C00);
        chk("blinker_g2_gen", {48'd0, gc_w}, 64'd2);
        start = 1'b0;
        cycle(3);

        // pause at tick 2, step twice, hold step, then resume
        load(64'h0000_0000_0000_1C00, 1'b0);
        cycle(2);
        pause = 1'b1;
        cycle(20);
        chk("paused_board", outp_w, 64'h0000_0000_0000_1C00);
        step = 1'b1; cycle(1); step = 1'b0; cycle(2);
        step = 1'b1; cycle(1); step = 1'b0; cycle(1);
        chk("step2_gen", {48'd0, gc_w}, 64'd2);
        step = 1'b1; cycle(5); step = 1'b0; cycle(1);
        chk("step_held_gen", {48'd0, gc_w}, 64'd3);
        pause = 1'b0;
        cycle(3);
        chk("resume_gen", {48'd0, gc_w}, 64'd4);
        cycle(6);

        // still life
        load(64'h303, 1'b0);
        cycle(4);
        chk("still_stable", {63'd0, st_w}, 64'd1);
        chk("still_board", outp_w, 64'h303);
        chk("still_gen", {48'd0, gc_w}, 64'd0);
        cycle(6);
        chk("still_hold", outp_w, 64'h303);

        // extinction, restart from HALT
        load(64'h1, 1'b0);
        cycle(4);
        chk("ext_flag", {63'd0, ex_w}, 64'd1);
        chk("ext_gen", {48'd0, gc_w}, 64'd1);
        chk("ext_running", {63'd0, run_w}, 64'd0);

        // edge wrap versus dead border
        load(64'h38, 1'b0);
        cycle(4);
        chk("wrap_board", outp_w, 64'h1000_0000_0000_1010);
        chk("nowrap_board", outp_n, 64'h1010);
        cycle(4);
        chk("nowrap_ext", {63'd0, ex_n}, 64'd1);
        chk("nowrap_ext_gen", {48'd0, gc_n}, 64'd2);

        // empty seed
        load(64'd0, 1'b0);
        cycle(4);
        chk("zero_stable", {63'd0, st_w}, 64'd1);
        chk("zero_gen", {48'd0, gc_w}, 64'd0);

        // randomized games with random pause/step/restart activity
        repeat (30) begin
            logic [63:0] s;
            s = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) s = s & {$urandom, $urandom};
            load(s, ($urandom_range(0, 3) == 0));
            repeat (40) begin
                if ($urandom_range(0, 7) == 0) pause = ~pause;
                step = ($urandom_range(0, 2) == 0);
                start = ($urandom_range(0, 39) == 0);
                cycle(1);
            end
            start = 1'b0; step = 1'b0; pause = 1'b0;
            cycle(1);
        end

        // asynchronous reset mid-run takes effect before any clock edge
        load(64'h0000_0000_0000_1C00, 1'b0);
        cycle(6);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_status();
        cycle(2);
        reset = 1'b0;
        cycle(3);

        chk("w_queue_drained", 64'(q_w.size()), 64'd0);
        chk("n_queue_drained", 64'(q_n.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
